// File: rtl/nodf_mon_pkg.sv
// Purpose: shared types and constants for the handshake monitor.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package nodf_mon_pkg;

    // Default width of every counter and cycle stamp.
    localparam int CNT_W_DEFAULT = 32;

    // Monitor state. The encodings are visible on the status output.
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ACTIVE   = 2'd1,
        ST_STALL    = 2'd2,
        ST_FINISHED = 2'd3
    } mon_state_t;

endpackage

// File: rtl/nodf_sat_counter.sv
// Purpose: W-bit up counter with enable that sticks at all-ones instead of wrapping.
// Latency: count reflects an enable one clock later; async reset clears it immediately.
// Backpressure: none; the enable is the only control.
//
// Ports:
//   clock  - counting clock
//   reset  - asynchronous active-high clear
//   en     - increment this cycle
//   count  - current value
module nodf_sat_counter #(
    parameter int W = 32
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         en,
    output logic [W-1:0] count
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (en && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/nodf_module_if.sv
// Purpose: passive monitor of an ap_start/ap_ready/ap_done/ap_continue block interface;
//          tracks block state, counts cycles, ready pulses, done handshakes and stall cycles.
// Latency: every output is registered and reflects the inputs sampled on the previous edge.
// Backpressure: none; the monitor only observes and never stalls the block.
//
// Ports:
//   clock, reset              - clock and asynchronous active-high reset
//   ap_start, ap_ready,
//   ap_done, ap_continue      - monitored handshake signals
//   finish                    - end-of-test; freezes everything until reset
//   status                    - current state (IDLE/ACTIVE/STALL/FINISHED)
//   cycle_cnt, ready_cnt,
//   done_cnt, stall_cnt       - saturating event counters
//   first_ready               - cycle stamp of the first ready pulse
//   last_interval             - distance between the two most recent ready pulses
//   finished                  - sticky end-of-test flag
module nodf_module_if
    import nodf_mon_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ap_start,
    input  logic             ap_ready,
    input  logic             ap_done,
    input  logic             ap_continue,
    input  logic             finish,
    output logic [1:0]       status,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] ready_cnt,
    output logic [CNT_W-1:0] done_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] first_ready,
    output logic [CNT_W-1:0] last_interval,
    output logic             finished
);

    // Unknown inputs must never move the monitor: only a clean 1 counts as asserted.
    logic start_s;
    logic ready_s;
    logic done_s;
    logic cont_s;
    logic finish_s;

    assign start_s  = (ap_start    === 1'b1);
    assign ready_s  = (ap_ready    === 1'b1);
    assign done_s   = (ap_done     === 1'b1);
    assign cont_s   = (ap_continue === 1'b1);
    assign finish_s = (finish      === 1'b1);

    mon_state_t state;
    mon_state_t state_nxt;

    // Everything freezes once FINISHED is reached. The cycle that samples finish is
    // still a live cycle, so its events are counted before the freeze.
    logic live;
    assign live = (state != ST_FINISHED);

    // ------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (finish_s) begin
            state_nxt = ST_FINISHED;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_s) begin
                        state_nxt = ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (done_s) begin
                        if (cont_s) begin
                            state_nxt = start_s ? ST_ACTIVE : ST_IDLE;
                        end else begin
                            state_nxt = ST_STALL;
                        end
                    end
                end
                ST_STALL: begin
                    if (cont_s) begin
                        state_nxt = start_s ? ST_ACTIVE : ST_IDLE;
                    end
                end
                ST_FINISHED: begin
                    state_nxt = ST_FINISHED;
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    assign status = state;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            finished <= 1'b0;
        end else if (state_nxt == ST_FINISHED) begin
            finished <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Event counters
    // ------------------------------------------------------------------
    logic cycle_en;
    logic ready_en;
    logic done_en;
    logic stall_en;

    assign cycle_en = live;
    assign ready_en = live && ready_s;
    // Done handshakes count in any live state, not only ACTIVE/STALL.
    assign done_en  = live && done_s && cont_s;
    assign stall_en = (state == ST_STALL);

    nodf_sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clock (clock),
        .reset (reset),
        .en    (cycle_en),
        .count (cycle_cnt)
    );

    nodf_sat_counter #(.W(CNT_W)) u_ready_cnt (
        .clock (clock),
        .reset (reset),
        .en    (ready_en),
        .count (ready_cnt)
    );

    nodf_sat_counter #(.W(CNT_W)) u_done_cnt (
        .clock (clock),
        .reset (reset),
        .en    (done_en),
        .count (done_cnt)
    );

    nodf_sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clock (clock),
        .reset (reset),
        .en    (stall_en),
        .count (stall_cnt)
    );

    // ------------------------------------------------------------------
    // Ready timestamps
    // ------------------------------------------------------------------
    // Stamps use the pre-increment cycle count, i.e. the index of the cycle in which
    // ap_ready was sampled. Once cycle_cnt saturates, successive stamps are equal and
    // the interval reads 0, which is the only honest answer at that point.
    logic             seen_ready;
    logic [CNT_W-1:0] last_stamp;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            seen_ready    <= 1'b0;
            last_stamp    <= '0;
            first_ready   <= '0;
            last_interval <= '0;
        end else if (ready_en) begin
            if (!seen_ready) begin
                first_ready <= cycle_cnt;
                seen_ready  <= 1'b1;
            end else begin
                last_interval <= cycle_cnt - last_stamp;
            end
            last_stamp <= cycle_cnt;
        end
    end

endmodule

// File: tb/tb_nodf_module_if.sv
module tb_nodf_module_if;

    logic clock = 1'b0;
    logic reset;
    logic ap_start, ap_ready, ap_done, ap_continue, finish;

    logic [1:0]  status;
    logic [31:0] cycle_cnt, ready_cnt, done_cnt, stall_cnt, first_ready, last_interval;
    logic        finished;

    logic [1:0]  status4;
    logic [3:0]  cycle_cnt4, ready_cnt4, done_cnt4, stall_cnt4, first_ready4, last_interval4;
    logic        finished4;

    int tests  = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    always #5 clock = ~clock;

    nodf_module_if #(.CNT_W(32)) dut (
        .clock(clock), .reset(reset),
        .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done),
        .ap_continue(ap_continue), .finish(finish),
        .status(status), .cycle_cnt(cycle_cnt), .ready_cnt(ready_cnt),
        .done_cnt(done_cnt), .stall_cnt(stall_cnt), .first_ready(first_ready),
        .last_interval(last_interval), .finished(finished)
    );

    nodf_module_if #(.CNT_W(4)) dut4 (
        .clock(clock), .reset(reset),
        .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done),
        .ap_continue(ap_continue), .finish(finish),
        .status(status4), .cycle_cnt(cycle_cnt4), .ready_cnt(ready_cnt4),
        .done_cnt(done_cnt4), .stall_cnt(stall_cnt4), .first_ready(first_ready4),
        .last_interval(last_interval4), .finished(finished4)
    );

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: one step per sampled edge, counters as plain integers
    // clipped at the 32-bit ceiling. State numbers: 0 idle, 1 active, 2 stall, 3 finished.
    // ------------------------------------------------------------------
    localparam longint CAP = 64'h0000_0000_FFFF_FFFF;

    int     m_st;
    longint m_cyc, m_rdy, m_done, m_stall, m_first, m_int, m_last;
    bit     m_seen;

    function automatic longint bump(input longint v);
        return (v >= CAP) ? CAP : v + 1;
    endfunction

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_st = 0; m_cyc = 0; m_rdy = 0; m_done = 0; m_stall = 0;
            m_first = 0; m_int = 0; m_last = 0; m_seen = 0;
        end else if (m_st != 3) begin
            bit s, r, d, c, f;
            s = (ap_start === 1'b1);
            r = (ap_ready === 1'b1);
            d = (ap_done === 1'b1);
            c = (ap_continue === 1'b1);
            f = (finish === 1'b1);
            if (r) begin
                if (m_seen) m_int = m_cyc - m_last;
                else        m_first = m_cyc;
                m_seen = 1;
                m_last = m_cyc;
                m_rdy  = bump(m_rdy);
            end
            if (d && c)    m_done  = bump(m_done);
            if (m_st == 2) m_stall = bump(m_stall);
            m_cyc = bump(m_cyc);
            if (f)                            m_st = 3;
            else if (m_st == 0 && s)          m_st = 1;
            else if (m_st == 1 && d && !c)    m_st = 2;
            else if ((m_st == 1 && d && c) || (m_st == 2 && c))
                                              m_st = s ? 1 : 0;
        end
    end

    // Compare process: checks every output against the model once per cycle.
    always @(negedge clock) begin
        if (cmp_en) begin
            check("status",        status,        m_st);
            check("cycle_cnt",     cycle_cnt,     m_cyc);
            check("ready_cnt",     ready_cnt,     m_rdy);
            check("done_cnt",      done_cnt,      m_done);
            check("stall_cnt",     stall_cnt,     m_stall);
            check("first_ready",   first_ready,   m_first);
            check("last_interval", last_interval, m_int);
            check("finished",      finished,      longint'(m_st == 3));
        end
    end

    // ------------------------------------------------------------------
    // Stimulus: inputs change 1 time unit after a rising edge.
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        ap_start = 0; ap_ready = 0; ap_done = 0; ap_continue = 0; finish = 0;
    endtask

    // Three reset cycles; the first edge after return is cycle index 0.
    task automatic do_reset();
        idle_inputs();
        reset = 1;
        repeat (3) tick();
        reset = 0;
    endtask

    initial begin
        reset = 1;
        idle_inputs();
        #1;
        do_reset();
        cmp_en = 1'b1;

        // Reset state
        check("rst_status",    status,    0);
        check("rst_cycle_cnt", cycle_cnt, 0);
        check("rst_finished",  finished,  0);

        // Idle block: ready pulses at 5, 9, 13 and finish at 20; extra ready after finish.
        for (int n = 0; n < 25; n++) begin
            ap_ready = (n == 5 || n == 9 || n == 13 || n == 22);
            finish   = (n == 20);
            tick();
            if (n == 19) check("idle_status_before_finish", status, 0);
            if (n == 20) check("idle_finished_next_cycle", finished, 1);
        end
        idle_inputs();
        check("idle_ready_cnt",     ready_cnt,     3);
        check("idle_first_ready",   first_ready,   5);
        check("idle_last_interval", last_interval, 4);
        check("idle_cycle_frozen",  cycle_cnt,     21);
        check("idle_status_fin",    status,        3);

        // Stall: start at 2, done 6..9, continue at 9 only. Also resets out of FINISHED.
        do_reset();
        check("stall_rst_status",   status,   0);
        check("stall_rst_finished", finished, 0);
        for (int n = 0; n < 13; n++) begin
            ap_start    = (n == 2);
            ap_done     = (n >= 6 && n <= 9);
            ap_continue = (n == 9);
            tick();
            if (n == 3) check("stall_active", status, 1);
            if (n >= 6 && n <= 8) check("stall_in_stall", status, 2);
            if (n == 9) begin
                check("stall_idle_at_10", status,    0);
                check("stall_cnt_3",      stall_cnt, 3);
                check("stall_done_cnt_1", done_cnt,  1);
            end
        end
        idle_inputs();

        // Simultaneous ready and finish at cycle 4.
        do_reset();
        for (int n = 0; n < 10; n++) begin
            ap_ready = (n == 3 || n == 4 || n == 7);
            finish   = (n == 4);
            tick();
            if (n == 3) check("sim_ready_before", ready_cnt, 1);
            if (n == 4) begin
                check("sim_ready_once", ready_cnt, 2);
                check("sim_finished",   finished,  1);
            end
        end
        idle_inputs();
        check("sim_ready_after_ignored", ready_cnt,     2);
        check("sim_interval",            last_interval, 1);

        // Saturation on the 4-bit instance: ready high for 20 cycles.
        do_reset();
        for (int n = 0; n < 20; n++) begin
            ap_ready = 1;
            tick();
            check("sat4_ready_cnt", ready_cnt4, (n + 1 > 15) ? 15 : n + 1);
        end
        idle_inputs();
        check("sat4_ready_final", ready_cnt4, 15);
        check("sat4_cycle_final", cycle_cnt4, 15);
        check("sat32_ready",      ready_cnt,  20);

        // Mid-run reset while ACTIVE with ready_cnt = 7.
        do_reset();
        for (int n = 0; n < 7; n++) begin
            ap_start = (n == 0);
            ap_ready = 1;
            tick();
        end
        idle_inputs();
        check("mid_ready_7",       ready_cnt, 7);
        check("mid_status_active", status,    1);
        #2;
        reset = 1;
        #1;
        check("mid_async_ready",    ready_cnt,   0);
        check("mid_async_cycle",    cycle_cnt,   0);
        check("mid_async_status",   status,      0);
        check("mid_async_first",    first_ready, 0);
        tick();
        tick();
        reset = 0;
        for (int n = 0; n < 3; n++) begin
            ap_ready = 1;
            tick();
        end
        idle_inputs();
        check("mid_restart_ready", ready_cnt,   3);
        check("mid_restart_cycle", cycle_cnt,   3);
        check("mid_restart_first", first_ready, 0);
        tick();

        cmp_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
